match_frame_counter: RTL
========================

# match_frame_counter

Downstream consumer of the serial 0101 pattern detector. The block counts the detector's one-cycle match pulses over fixed frames of FRAME_LEN enabled bit-times. At each frame boundary it hands the per-frame match count to a host-side consumer through a one-entry valid/ready output register. Frames that complete while the output register is still occupied are dropped and flagged.

## Interface
- FRAME_LEN, 16: bit-times per frame; legal range 2..256.
- CNT_W, 5: width of the count field; the count saturates at 2^CNT_W-1.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  bit-time strobe; high when the detector consumed a serial bit this cycle; det is ignored when low.
- det  input  1  match pulse from the detector's out, sampled only when en=1.
- cnt_ready  input  1  consumer accepts cnt_data this cycle.
- cnt_valid  output  1  cnt_data/cnt_sat hold a completed frame result.
- cnt_data  output  CNT_W  number of matches in the reported frame.
- cnt_sat  output  1  the reported frame's count saturated.
- frame_lost  output  1  one-cycle pulse: a completed frame was discarded.

## Operation
- Internal state:
  - position counter pos, width clog2(FRAME_LEN), range 0..FRAME_LEN-1;
  - accumulator acc (CNT_W bits) plus acc_sat;
  - output register (cnt_data, cnt_sat) with a two-state FSM, EMPTY/FULL, that drives cnt_valid.
- Bit-time (en=1, pos<FRAME_LEN-1):
  - pos increments by 1.
  - If det=1, acc increments by 1, saturating at all-ones; an increment attempted at all-ones sets acc_sat.
  - If det=0, acc and acc_sat hold.
- Frame end (en=1, pos=FRAME_LEN-1):
  - final = acc + det with the same saturation rule, final_sat = acc_sat or saturation occurring on this add.
  - pos wraps to 0; acc and acc_sat clear to 0 on the same edge.
  - The next frame begins counting on the following enabled bit-time.
- Output FSM:
  - EMPTY + frame end: load final/final_sat, go to FULL.
  - FULL + cnt_ready=1, no frame end: go to EMPTY. cnt_data/cnt_sat keep their last value; they are don't-care while invalid.
  - FULL + cnt_ready=1 + frame end on the same cycle: load the new result, stay FULL. No loss.
  - FULL + cnt_ready=0 + frame end: keep the old result, discard the new one, pulse frame_lost=1 for that cycle's following edge.
  - FULL + cnt_ready=0, no frame end: hold. cnt_data/cnt_sat must be stable.
- en=0: pos, acc and acc_sat hold; det is ignored. The output handshake still operates normally.
- cnt_ready while EMPTY has no effect.

## Timing
- Reset (asynchronous, effective immediately): pos=0, acc=0, acc_sat=0, FSM=EMPTY, cnt_valid=0, cnt_data=0, cnt_sat=0, frame_lost=0.
  - Reset mid-frame discards the partial count and any unaccepted result.
  - The first enabled bit after reset release is frame position 0.
- Latency: cnt_valid rises in the cycle after the clock edge that samples the final bit-time (registered output). This includes a det=1 in that final bit.
- frame_lost is registered: high for exactly one cycle, starting after the edge on which the drop occurs.
- Transfer occurs on a rising edge with cnt_valid=1 and cnt_ready=1. Once cnt_valid is asserted, it must not drop without a transfer.
- No combinational path from cnt_ready to cnt_valid or cnt_data. All outputs come directly from flops.
- Sustained throughput: one result per FRAME_LEN enabled cycles. With FRAME_LEN=2 and cnt_ready held high, no frame is lost.

## Test plan
- Reset and basic count: FRAME_LEN=16, en=1 constant, det pulses at positions 3, 7 and 15, cnt_ready=1 -> cnt_valid=1 for one cycle after position 15 with cnt_data=3 and cnt_sat=0, then 0 again.
- Gaps in en: same det pattern, but en low for 5 cycles after position 4, with det=1 during the gap -> the gap det is ignored, cnt_data=3, and cnt_valid appears 5 cycles later than in the previous test.
- Saturation: CNT_W=2, FRAME_LEN=8, det=1 every enabled cycle -> cnt_data=3, cnt_sat=1. The next frame, with 2 pulses, reports cnt_data=2, cnt_sat=0.
- Backpressure and loss: cnt_ready=0 across two full frames with counts 1 and 2 -> cnt_data stays 1 and stable; frame_lost pulses once at the end of frame 2. With cnt_ready=1 afterwards, the value 1 transfers and cnt_valid then drops.
- Simultaneous accept and frame end: FULL with value 4, cnt_ready=1 on the cycle of the next frame end (count 2) -> cnt_valid stays 1, cnt_data becomes 2, frame_lost=0.
- Asynchronous reset mid-frame: assert rst at position 9 with acc=2 while FULL -> all outputs 0 immediately. A subsequent frame with 1 pulse reports cnt_data=1 after FRAME_LEN enabled bits.

Source files
------------

// File: rtl/match_frame_counter.sv
// Counts detector match pulses over frames of FRAME_LEN enabled bit-times and
// reports each frame's count through a one-entry valid/ready output register.
module match_frame_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             det_i,
  input  logic             cnt_ready_i,
  output logic             cnt_valid_o,
  output logic [CNT_W-1:0] cnt_data_o,
  output logic             cnt_sat_o,
  output logic             frame_lost_o
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               acc_sat_q, acc_sat_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic               sat_q, sat_d;
  logic               lost_q, lost_d;

  logic               frame_end;
  logic               inc;
  logic               acc_full;
  logic [CNT_W-1:0]   sum_val;
  logic               sum_sat;

  assign frame_end = en_i && (pos_q == LAST);
  assign inc       = en_i && det_i;
  assign acc_full  = &acc_q;
  // Shared by mid-frame accumulation and the frame-end final value.
  assign sum_val   = (inc && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
  assign sum_sat   = acc_sat_q | (inc & acc_full);

  always_comb begin
    pos_d     = pos_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    if (en_i) begin
      if (frame_end) begin
        pos_d     = '0;
        acc_d     = '0;
        acc_sat_d = 1'b0;
      end else begin
        pos_d     = pos_q + PW'(1);
        acc_d     = sum_val;
        acc_sat_d = sum_sat;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sat_d   = sat_q;
    lost_d  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (frame_end) begin
          data_d  = sum_val;
          sat_d   = sum_sat;
          state_d = FULL;
        end
      end
      FULL: begin
        if (frame_end) begin
          if (cnt_ready_i) begin
            data_d = sum_val;
            sat_d  = sum_sat;
          end else begin
            lost_d = 1'b1;
          end
        end else if (cnt_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      pos_q     <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      data_q    <= data_d;
      sat_q     <= sat_d;
      lost_q    <= lost_d;
    end
  end

  assign cnt_valid_o  = (state_q == FULL);
  assign cnt_data_o   = data_q;
  assign cnt_sat_o    = sat_q;
  assign frame_lost_o = lost_q;

endmodule
